// File: rtl/inst_fetch_queue_pkg.sv
// rtl/inst_fetch_queue_pkg.sv - shared types and constants for the instruction fetch queue
package inst_fetch_queue_pkg;

  typedef logic [31:0] word_t;

  typedef struct packed {
    word_t pc;
    word_t inst;
    logic  adel;
  } fetch_entry_t;

  localparam word_t PC_RESET = 32'hbfc0_0000;

  typedef enum logic [1:0] {
    FETCH_RUN,
    FETCH_ADEL_WAIT,
    FETCH_ADEL_DONE
  } fetch_mode_t;

endpackage

// File: rtl/inst_fetch_queue_fetch_fifo.sv
// rtl/inst_fetch_queue_fetch_fifo.sv - synchronous FIFO with flush, generic element type
module fetch_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = logic [31:0],
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          flush,
  input  logic          push,
  input  T              push_data,
  input  logic          pop,
  output T              head,
  output logic [CW-1:0] count
);

  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  T              mem [DEPTH];
  logic          do_push;
  logic          do_pop;

  function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // A push into a full FIFO is accepted only when the head leaves in the same cycle.
  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!resetn || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= bump(wr_ptr);
      if (do_pop)  rd_ptr <= bump(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/inst_fetch_queue.sv
// rtl/inst_fetch_queue.sv - sequential fetch front-end with redirect flush and word FIFO
// Optional FETCH_ADEL_EN: a misaligned redirect target yields one address-error entry.
module inst_fetch_queue
  import inst_fetch_queue_pkg::*;
#(
  parameter int    DEPTH           = 4,
  parameter int    MAX_OUTSTANDING = 2,
  parameter word_t RESET_PC        = PC_RESET
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_req,
  output logic        inst_wr,
  output logic [1:0]  inst_size,
  output logic [31:0] inst_addr,
  output logic [31:0] inst_wdata,
  input  logic [31:0] inst_rdata,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst,
  output logic        out_adel
);

  localparam int FCW = $clog2(DEPTH + 1);
  localparam int TCW = $clog2(MAX_OUTSTANDING + 1);
  localparam int SW  = FCW + 1;

  logic [FCW-1:0] fifo_count;
  logic [TCW-1:0] outstanding;
  logic [TCW-1:0] discard;
  logic [TCW-1:0] discard_n;
  logic [SW-1:0]  fifo_count_n;
  logic [SW-1:0]  outstanding_n;
  fetch_entry_t   fifo_in;
  fetch_entry_t   fifo_head;
  word_t          tag_head;
  word_t          fetch_pc;
  word_t          fetch_pc_n;
  word_t          target_pc;
  fetch_mode_t    mode;
  fetch_mode_t    mode_n;
  logic           stale_req;
  logic           stale_n;
  logic           accept;
  logic           ret;
  logic           pop;
  logic           drop;
  logic           push_word;
  logic           push_adel;
  logic           fifo_push;
  logic           can_issue;

  assign accept    = inst_req & inst_addr_ok;
  assign ret       = inst_data_ok & (outstanding != '0);
  assign pop       = out_valid & out_ready;
  assign drop      = ret & (discard != '0);
  assign push_word = ret & ~drop & ~redirect_valid;
  assign fifo_push = push_word | push_adel;

`ifdef FETCH_ADEL_EN
  assign target_pc = redirect_pc;
  // The error entry waits until every stale request has been accepted and returned.
  assign push_adel = (mode == FETCH_ADEL_WAIT) && (outstanding == '0) && !inst_req &&
                     !redirect_valid && ((fifo_count != FCW'(DEPTH)) || pop);

  always_comb begin
    mode_n = mode;
    if (redirect_valid)
      mode_n = (redirect_pc[1:0] != 2'b00) ? FETCH_ADEL_WAIT : FETCH_RUN;
    else if (push_adel)
      mode_n = FETCH_ADEL_DONE;
  end
`else
  assign target_pc = redirect_pc & ~32'h3;
  assign push_adel = 1'b0;
  assign mode_n    = FETCH_RUN;
`endif

  assign fifo_in = push_adel ? fetch_entry_t'{pc: fetch_pc, inst: '0, adel: 1'b1}
                             : fetch_entry_t'{pc: tag_head, inst: inst_rdata, adel: 1'b0};

  always_comb begin
    fifo_count_n  = redirect_valid ? '0 : SW'(fifo_count) + SW'(fifo_push) - SW'(pop);
    outstanding_n = SW'(outstanding) + SW'(accept) - SW'(ret);

    fetch_pc_n = fetch_pc;
    if (redirect_valid)
      fetch_pc_n = target_pc;
    else if (accept && !stale_req)
      fetch_pc_n = fetch_pc + 32'd4;

    // A request still waiting for addr_ok across a redirect belongs to the old stream.
    stale_n   = inst_req & ~inst_addr_ok & (stale_req | redirect_valid);
    discard_n = redirect_valid ? outstanding_n[TCW-1:0]
                               : discard - TCW'(drop) + TCW'(accept & stale_req);

    can_issue = ((fifo_count_n + outstanding_n) < SW'(DEPTH)) &&
                (outstanding_n < SW'(MAX_OUTSTANDING)) &&
                (mode_n == FETCH_RUN);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      inst_req  <= 1'b0;
      inst_addr <= RESET_PC;
      fetch_pc  <= RESET_PC;
      discard   <= '0;
      stale_req <= 1'b0;
      mode      <= FETCH_RUN;
    end else begin
      fetch_pc  <= fetch_pc_n;
      discard   <= discard_n;
      stale_req <= stale_n;
      mode      <= mode_n;
      if (!(inst_req && !inst_addr_ok)) begin
        inst_req  <= can_issue;
        inst_addr <= fetch_pc_n;
      end
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .T     (fetch_entry_t)
  ) u_word_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .flush     (redirect_valid),
    .push      (fifo_push),
    .push_data (fifo_in),
    .pop       (pop),
    .head      (fifo_head),
    .count     (fifo_count)
  );

  // Every accepted request leaves a tag here, so its occupancy is the outstanding count.
  fetch_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .T     (word_t)
  ) u_tag_queue (
    .clk       (clk),
    .resetn    (resetn),
    .flush     (1'b0),
    .push      (accept),
    .push_data (inst_addr),
    .pop       (ret),
    .head      (tag_head),
    .count     (outstanding)
  );

  assign inst_wr    = 1'b0;
  assign inst_size  = 2'b10;
  assign inst_wdata = 32'h0;
  assign out_valid  = (fifo_count != '0);
  assign out_pc     = fifo_head.pc;
  assign out_inst   = fifo_head.inst;
  assign out_adel   = fifo_head.adel;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// tb/tb_inst_fetch_queue.sv - directed self-checking bench for inst_fetch_queue
module tb_inst_fetch_queue;

  logic        clk = 1'b0;
  logic        resetn;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_req;
  logic        inst_wr;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr;
  logic [31:0] inst_wdata;
  logic [31:0] inst_rdata;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic        out_adel;

  logic        aok_en;
  logic        data_en;
  logic        dok_redirect;
  logic [31:0] bus_q[$];
  logic [31:0] acc_addr[$];
  logic [31:0] pop_pc[$];
  logic [31:0] pop_inst[$];
  logic        pop_adel[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          acc_snap;
  logic [31:0] exp_pc;

  inst_fetch_queue dut (
    .clk            (clk),
    .resetn         (resetn),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_req       (inst_req),
    .inst_wr        (inst_wr),
    .inst_size      (inst_size),
    .inst_addr      (inst_addr),
    .inst_wdata     (inst_wdata),
    .inst_rdata     (inst_rdata),
    .inst_addr_ok   (inst_addr_ok),
    .inst_data_ok   (inst_data_ok),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_inst       (out_inst),
    .out_adel       (out_adel)
  );

  always #5 clk = ~clk;

  // Bus returns ~addr as the instruction word, one cycle or more after acceptance.
  always @(posedge clk) begin
    #2;
    inst_addr_ok = aok_en;
    inst_data_ok = data_en && (bus_q.size() > 0);
    inst_rdata   = (bus_q.size() > 0) ? ~bus_q[0] : 32'h0;
  end

  always @(negedge clk) begin
    if (resetn) begin
      if (inst_data_ok && bus_q.size() > 0) begin
        if (redirect_valid) dok_redirect = 1'b1;
        void'(bus_q.pop_front());
      end
      if (inst_req && inst_addr_ok) begin
        bus_q.push_back(inst_addr);
        acc_addr.push_back(inst_addr);
      end
      if (out_valid && out_ready) begin
        pop_pc.push_back(out_pc);
        pop_inst.push_back(out_inst);
        pop_adel.push_back(out_adel);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pc_at(input int i);
    return (i < pop_pc.size()) ? pop_pc[i] : 32'hdead_beef;
  endfunction

  function automatic logic [31:0] inst_at(input int i);
    return (i < pop_inst.size()) ? pop_inst[i] : 32'hdead_beef;
  endfunction

  function automatic logic adel_at(input int i);
    return (i < pop_adel.size()) ? pop_adel[i] : 1'bx;
  endfunction

  function automatic logic [31:0] acc_at(input int i);
    return (i < acc_addr.size()) ? acc_addr[i] : 32'hdead_beef;
  endfunction

  task automatic clear_pops();
    pop_pc.delete();
    pop_inst.delete();
    pop_adel.delete();
  endtask

  task automatic do_reset();
    resetn         = 1'b0;
    out_ready      = 1'b0;
    aok_en         = 1'b0;
    data_en        = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    step(2);
    check("rst_req", {31'b0, inst_req}, 32'h0);
    check("rst_valid", {31'b0, out_valid}, 32'h0);
    check("rst_addr", inst_addr, 32'hbfc0_0000);
    bus_q.delete();
    acc_addr.delete();
    clear_pops();
    dok_redirect = 1'b0;
    resetn       = 1'b1;
  endtask

  task automatic pulse_redirect(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    step(1);
    redirect_valid = 1'b0;
  endtask

  initial begin
    do_reset();
    check("rst_size", {30'b0, inst_size}, 32'h2);
    check("rst_wr", {31'b0, inst_wr}, 32'h0);
    check("rst_wdata", inst_wdata, 32'h0);

    // Free-flowing stream from the reset vector.
    out_ready = 1'b1;
    aok_en    = 1'b1;
    data_en   = 1'b1;
    step(20);
    check("t1_npop", {31'b0, pop_pc.size() >= 6}, 32'h1);
    for (int i = 0; i < 6; i++) begin
      exp_pc = 32'hbfc0_0000 + 32'(4 * i);
      check($sformatf("t1_pc%0d", i), pc_at(i), exp_pc);
      check($sformatf("t1_inst%0d", i), inst_at(i), ~exp_pc);
    end
    check("t1_adel", {31'b0, adel_at(0)}, 32'h0);

    // Backpressure: stops after DEPTH accepts, resumes at bfc00010.
    do_reset();
    aok_en  = 1'b1;
    data_en = 1'b1;
    step(15);
    check("t2_acc", acc_addr.size(), 32'd4);
    check("t2_req", {31'b0, inst_req}, 32'h0);
    check("t2_valid", {31'b0, out_valid}, 32'h1);
    check("t2_head", out_pc, 32'hbfc0_0000);
    out_ready = 1'b1;
    step(15);
    check("t2_resume_addr", acc_at(4), 32'hbfc0_0010);
    check("t2_pop4_pc", pc_at(4), 32'hbfc0_0010);
    check("t2_pop4_inst", inst_at(4), ~32'hbfc0_0010);

    // Two in flight when redirected: both responses dropped.
    do_reset();
    out_ready = 1'b1;
    aok_en    = 1'b1;
    step(8);
    check("t3_acc", acc_addr.size(), 32'd2);
    check("t3_req", {31'b0, inst_req}, 32'h0);
    data_en = 1'b1;
    pulse_redirect(32'h8000_0100);
    clear_pops();
    step(15);
    check("t3_pc0", pc_at(0), 32'h8000_0100);
    check("t3_inst0", inst_at(0), ~32'h8000_0100);
    check("t3_pc1", pc_at(1), 32'h8000_0104);
    check("t3_acc2", acc_at(2), 32'h8000_0100);

    // Redirect while a request waits for addr_ok.
    do_reset();
    out_ready = 1'b1;
    data_en   = 1'b1;
    step(3);
    check("t4_req", {31'b0, inst_req}, 32'h1);
    pulse_redirect(32'h8000_0200);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("t4_hold_req%0d", i), {31'b0, inst_req}, 32'h1);
      check($sformatf("t4_hold_addr%0d", i), inst_addr, 32'hbfc0_0000);
      step(1);
    end
    aok_en = 1'b1;
    step(12);
    check("t4_acc0", acc_at(0), 32'hbfc0_0000);
    check("t4_acc1", acc_at(1), 32'h8000_0200);
    check("t4_pc0", pc_at(0), 32'h8000_0200);

    // Redirect coinciding with data_ok and a pop.
    do_reset();
    aok_en  = 1'b1;
    data_en = 1'b1;
    step(12);
    check("t5_acc", acc_addr.size(), 32'd4);
    out_ready = 1'b1;
    step(1);
    out_ready = 1'b0;
    step(1);
    out_ready = 1'b1;
    pulse_redirect(32'h8000_0300);
    check("t5_empty", {31'b0, out_valid}, 32'h0);
    check("t5_dok", {31'b0, dok_redirect}, 32'h1);
    clear_pops();
    step(10);
    check("t5_pc0", pc_at(0), 32'h8000_0300);
    check("t5_inst0", inst_at(0), ~32'h8000_0300);

    // Misaligned redirect target.
    do_reset();
    out_ready = 1'b1;
    aok_en    = 1'b1;
    data_en   = 1'b1;
    step(6);
    pulse_redirect(32'h8000_0102);
    clear_pops();
    acc_snap = acc_addr.size();
    step(12);
`ifdef FETCH_ADEL_EN
    check("t6_npop", pop_pc.size(), 32'd1);
    check("t6_pc", pc_at(0), 32'h8000_0102);
    check("t6_inst", inst_at(0), 32'h0);
    check("t6_adel", {31'b0, adel_at(0)}, 32'h1);
    check("t6_req", {31'b0, inst_req}, 32'h0);
    check("t6_acc", acc_addr.size(), acc_snap);
    pulse_redirect(32'h8000_0200);
    clear_pops();
    step(10);
    check("t6_resume_pc", pc_at(0), 32'h8000_0200);
    check("t6_resume_adel", {31'b0, adel_at(0)}, 32'h0);
`else
    check("t6_pc", pc_at(0), 32'h8000_0100);
    check("t6_inst", inst_at(0), ~32'h8000_0100);
    check("t6_adel", {31'b0, adel_at(0)}, 32'h0);
    check("t6_acc", acc_at(acc_snap), 32'h8000_0100);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
